// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back formatter (RV32I).
//
// Captures the MEM-stage instruction, formats load data (byte/halfword
// extraction with sign/zero extension), and drives the register-bank write
// triple (rd, RegWrite, C). The same triple goes to the forwarding unit.
// A retired-instruction counter counts each instruction leaving WB once.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_*           instruction fields arriving from the MEM stage
//   stall           hold the WB register contents
//   flush           squash the instruction entering WB (wins over stall)
//   rd/RegWrite/C   register bank write index / enable / data
//   fwd_*           copies of the write triple for WB-to-EX forwarding
//   instret         retired-instruction count, wraps modulo 2^CNT_W
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_rd,
   input  logic [1:0]       mem_wb_sel,
   input  logic [2:0]       mem_funct3,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic [XLEN-1:0]  mem_load_word,
   input  logic [XLEN-1:0]  mem_pc_plus4,
   input  logic             stall,
   input  logic             flush,
   output logic [4:0]       rd,
   output logic             RegWrite,
   output logic [XLEN-1:0]  C,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic [CNT_W-1:0] instret
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [4:0]      rd;
      logic [1:0]      wb_sel;
      logic [2:0]      funct3;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] load_word;
      logic [XLEN-1:0] pc_plus4;
   } wb_req_t;

   wb_req_t st, nxt;

   always_comb begin
      nxt            = '0;
      nxt.valid      = mem_valid;
      nxt.reg_write  = mem_reg_write;
      nxt.rd         = mem_rd;
      nxt.wb_sel     = mem_wb_sel;
      nxt.funct3     = mem_funct3;
      nxt.alu_result = mem_alu_result;
      nxt.load_word  = mem_load_word;
      nxt.pc_plus4   = mem_pc_plus4;
   end

   // The instruction in WB retires on any edge where it leaves the stage:
   // either not stalled, or flushed (flush beats stall, and the squash only
   // applies to the incoming instruction, so the one in WB still counts).
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= '0;
         instret <= '0;
      end else begin
         if (st.valid && (!stall || flush))
            instret <= instret + CNT_W'(1);
         if (flush)
            st.valid <= 1'b0;
         else if (!stall)
            st <= nxt;
      end
   end

   // Load formatting: little-endian lanes, offset from the effective address.
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] wb_data;

   always_comb begin
      case (st.alu_result[1:0])
         2'd0:    ld_byte = st.load_word[7:0];
         2'd1:    ld_byte = st.load_word[15:8];
         2'd2:    ld_byte = st.load_word[23:16];
         default: ld_byte = st.load_word[31:24];
      endcase
      // Halfword select ignores address bit 0 (misaligned halves not split).
      ld_half = st.alu_result[1] ? st.load_word[31:16] : st.load_word[15:0];
      case (st.funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = st.load_word;
      endcase
   end

   always_comb begin
      case (st.wb_sel)
         2'b01:   wb_data = ld_data;
         2'b10:   wb_data = st.pc_plus4;
         default: wb_data = st.alu_result;   // 00 and reserved 11
      endcase
   end

   // x0 is never written or forwarded.
   assign rd        = st.rd;
   assign RegWrite  = st.valid & st.reg_write & (st.rd != 5'd0);
   assign C         = wb_data;
   assign fwd_valid = RegWrite;
   assign fwd_rd    = st.rd;
   assign fwd_data  = wb_data;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, mem_valid, mem_reg_write, stall, flush;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result, mem_load_word, mem_pc_plus4;

   logic [4:0]  rd, fwd_rd, rd4, fwd_rd4;
   logic        RegWrite, fwd_valid, RegWrite4, fwd_valid4;
   logic [31:0] C, fwd_data, C4, fwd_data4;
   logic [31:0] instret;
   logic [3:0]  instret4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
      .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
      .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
      .rd(rd), .RegWrite(RegWrite), .C(C), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret));

   wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
      .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
      .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
      .rd(rd4), .RegWrite(RegWrite4), .C(C4), .fwd_valid(fwd_valid4),
      .fwd_rd(fwd_rd4), .fwd_data(fwd_data4), .instret(instret4));

   // Reference model: tracks the instruction sitting in WB as its final
   // write-back value, plus a plain retirement count.
   bit          m_v, m_rw, m_known;
   logic [4:0]  m_rd;
   logic [31:0] m_c;
   int unsigned m_cnt;

   function automatic logic [31:0] ref_c(input logic [1:0] sel, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] lw,
                                         input logic [31:0] pc);
      int unsigned b, h;
      int          s;
      b = (lw >> (8 * (alu % 4))) % 256;
      h = (lw >> (16 * ((alu / 2) % 2))) % 65536;
      if (sel == 2'd2) return pc;
      if (sel != 2'd1) return alu;
      case (f3)
         3'd0: begin s = (b >= 128) ? int'(b) - 256 : int'(b); return 32'(s); end
         3'd4: return 32'(b);
         3'd1: begin s = (h >= 32768) ? int'(h) - 65536 : int'(h); return 32'(s); end
         3'd5: return 32'(h);
         default: return lw;
      endcase
   endfunction

   task automatic tick();
      if (rst) begin
         m_v = 0; m_rw = 0; m_rd = '0; m_c = '0; m_cnt = 0; m_known = 1;
      end else begin
         if (m_v && (!stall || flush)) m_cnt++;
         if (flush) begin
            m_v = 0; m_known = 0;
         end else if (!stall) begin
            m_v = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd; m_known = 1;
            m_c = ref_c(mem_wb_sel, mem_funct3, mem_alu_result, mem_load_word, mem_pc_plus4);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] r,
                        input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] lw, input logic [31:0] pc);
      mem_valid = v; mem_reg_write = rw; mem_rd = r; mem_wb_sel = sel;
      mem_funct3 = f3; mem_alu_result = alu; mem_load_word = lw; mem_pc_plus4 = pc;
   endtask

   task automatic idle();
      rst = 0; stall = 0; flush = 0;
      drive(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0b want 0", RegWrite); end
      checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd); end
      checks++; if (C !== 32'h0) begin errors++; $display("FAIL reset_c: got %h want 0", C); end
      checks++; if ({fwd_valid, fwd_rd, fwd_data} !== 38'h0) begin errors++; $display("FAIL reset_fwd: got %0b/%0d/%h want 0", fwd_valid, fwd_rd, fwd_data); end
      checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
   endtask

   task automatic test_alu_write();
      drive(1, 1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_0010);
      tick();
      idle();
      checks++; if (RegWrite !== 1'b1 || fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %0b/%0b want 1", RegWrite, fwd_valid); end
      checks++; if (rd !== 5'd5 || fwd_rd !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d want 5", rd); end
      checks++; if (C !== 32'h0000_1234 || fwd_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_c: got %h want 00001234", C); end
      checks++; if (instret !== 32'd0) begin errors++; $display("FAIL alu_instret_early: got %0d want 0", instret); end
      tick();
      checks++; if (instret !== 32'd1) begin errors++; $display("FAIL alu_instret: got %0d want 1", instret); end
   endtask

   task automatic test_load_format();
      logic [2:0]  f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [31:0] adr [5] = '{32'h1003, 32'h1003, 32'h1000, 32'h1002, 32'h1001};
      logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF01, 32'h0000_807F, 32'h807F_FF01};
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 5'd10 + 5'(i), 2'd1, f3[i], adr[i], 32'h807F_FF01, 32'h0);
         tick();
         checks++; if (C !== exp[i]) begin errors++; $display("FAIL load_fmt%0d: got %h want %h", i, C, exp[i]); end
      end
      idle();
      tick();
   endtask

   task automatic test_x0();
      int unsigned base;
      drive(1, 1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
      tick();
      idle();
      base = instret;
      checks++; if (RegWrite !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL x0_suppress: got %0b/%0b want 0", RegWrite, fwd_valid); end
      tick();
      checks++; if (instret !== base + 1) begin errors++; $display("FAIL x0_instret: got %0d want %0d", instret, base + 1); end
   endtask

   task automatic test_stall_flush();
      int unsigned base;
      drive(1, 1, 5'd7, 2'd0, 3'd0, 32'h0000_0077, 32'h0, 32'h0);
      tick();
      base = instret;
      stall = 1;
      drive(1, 1, 5'd9, 2'd2, 3'd0, 32'h0000_0099, 32'h0, 32'h0000_0999);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (rd !== 5'd7 || C !== 32'h77 || RegWrite !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got rd=%0d C=%h we=%0b want 7/77/1", i, rd, C, RegWrite); end
         checks++; if (instret !== base) begin errors++; $display("FAIL stall_instret%0d: got %0d want %0d", i, instret, base); end
      end
      stall = 0;
      tick();
      checks++; if (instret !== base + 1) begin errors++; $display("FAIL stall_release: got %0d want %0d", instret, base + 1); end
      // rd=9 entered on release; stall+flush together squashes the next one.
      drive(1, 1, 5'd3, 2'd0, 3'd0, 32'h33, 32'h0, 32'h0);
      stall = 1; flush = 1;
      tick();
      idle();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL stall_flush: got %0b want 0", RegWrite); end
      checks++; if (instret !== base + 2) begin errors++; $display("FAIL flush_count: got %0d want %0d", instret, base + 2); end
   endtask

   task automatic test_jal();
      drive(1, 1, 5'd1, 2'd2, 3'd0, $urandom, $urandom, 32'h0000_0104);
      tick();
      idle();
      checks++; if (C !== 32'h0000_0104 || RegWrite !== 1'b1 || rd !== 5'd1) begin errors++; $display("FAIL jal: got C=%h we=%0b rd=%0d want 104/1/1", C, RegWrite, rd); end
   endtask

   task automatic test_reset_midstream();
      drive(1, 1, 5'd12, 2'd0, 3'd0, 32'h1111_2222, 32'h0, 32'h0);
      tick();
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL mid_pre: got %0b want 1", RegWrite); end
      rst = 1;
      tick();
      rst = 0;
      idle();
      checks++; if (RegWrite !== 1'b0 || instret !== 32'd0 || instret4 !== 4'd0) begin errors++; $display("FAIL mid_reset: got we=%0b cnt=%0d cnt4=%0d want 0/0/0", RegWrite, instret, instret4); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 17; i++) begin
         drive(1, i[0], 5'(i), 2'(i), 3'(i), $urandom, $urandom, $urandom);
         tick();
      end
      idle();
      tick();
      checks++; if (instret4 !== 4'd1) begin errors++; $display("FAIL wrap4: got %0d want 1", instret4); end
      checks++; if (instret !== 32'd17) begin errors++; $display("FAIL wrap32: got %0d want 17", instret); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 49) == 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
               2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
         tick();
         checks++; if (RegWrite !== (m_v && m_rw && m_rd != 0) || fwd_valid !== RegWrite4) begin errors++; $display("FAIL rnd_we%0d: got %0b want %0b", n, RegWrite, m_v && m_rw && m_rd != 0); end
         if (m_known) begin
            checks++; if (rd !== m_rd || fwd_rd !== m_rd) begin errors++; $display("FAIL rnd_rd%0d: got %0d want %0d", n, rd, m_rd); end
            checks++; if (C !== m_c || fwd_data !== m_c) begin errors++; $display("FAIL rnd_c%0d: got %h want %h", n, C, m_c); end
         end
         checks++; if (instret !== m_cnt || instret4 !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt%0d: got %0d/%0d want %0d", n, instret, instret4, m_cnt); end
      end
      idle();
   endtask

   initial begin
      idle();
      m_v = 0; m_rw = 0; m_rd = '0; m_c = '0; m_cnt = 0; m_known = 0;
      test_reset();
      test_alu_write();
      test_load_format();
      test_x0();
      test_stall_flush();
      test_jal();
      test_reset_midstream();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
